// File: rtl/membank_argmax_pkg.sv
// Shared definitions for the membank argmax reader: bank geometry defaults and FSM state encodings.
// The optional zero-skip build is selected with MEMSCAN_SKIP_ZERO_EN (see membank_argmax_stage).
package membank_argmax_pkg;

  localparam int MEMBANK_WORD_WIDTH = 16;
  localparam int MEMBANK_MEM_DEPTH  = 64;
  localparam int MEMBANK_ADDR_WIDTH = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_t;

endpackage

// File: rtl/membank_argmax_stage.sv
// Registered running-maximum tracker for the bank scan; ties keep the earliest index.
// MEMSCAN_SKIP_ZERO_EN: when defined, zero words are empty slots and never qualify.
module membank_argmax_stage
  import membank_argmax_pkg::*;
#(
  parameter int WORD_WIDTH = MEMBANK_WORD_WIDTH,
  parameter int ADDR_WIDTH = MEMBANK_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  clear,
  input  logic                  valid,
  input  logic [ADDR_WIDTH-1:0] index,
  input  logic [WORD_WIDTH-1:0] data,
  output logic                  found,
  output logic [ADDR_WIDTH-1:0] best_index,
  output logic [WORD_WIDTH-1:0] best_value
);

  logic qualify;
  logic better;

`ifdef MEMSCAN_SKIP_ZERO_EN
  assign qualify = valid && (data != '0);
`else
  assign qualify = valid;
`endif

  // Strict greater-than: an equal later word never displaces the earlier one.
  assign better = qualify && (!found || (data > best_value));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      found      <= 1'b0;
      best_index <= '0;
      best_value <= '0;
    end else if (clear) begin
      found      <= 1'b0;
      best_index <= '0;
      best_value <= '0;
    end else if (better) begin
      found      <= 1'b1;
      best_index <= index;
      best_value <= data;
    end
  end

endmodule

// File: rtl/membank_argmax_reader.sv
// Scans bank entries 0..count-1 through the read port and reports the index/value of the largest word.
// MEMSCAN_SKIP_ZERO_EN (handled in membank_argmax_stage) makes zero words ineligible.
//
// state    | meaning
// ST_IDLE  | waiting for start; results hold
// ST_SCAN  | rd_en high, rd_index walking 0..count-1
// ST_DRAIN | last reads still in flight through the compare pipeline
// ST_DONE  | one-cycle done pulse
module membank_argmax_reader
  import membank_argmax_pkg::*;
#(
  parameter int WORD_WIDTH = MEMBANK_WORD_WIDTH,
  parameter int MEM_DEPTH  = MEMBANK_MEM_DEPTH,
  parameter int ADDR_WIDTH = MEMBANK_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_entries,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_index,
  input  logic [WORD_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  found,
  output logic [ADDR_WIDTH-1:0] best_index,
  output logic [WORD_WIDTH-1:0] best_value
);

  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_W   = (ADDR_WIDTH+1)'(1);

  scan_state_t state_q, state_d;

  logic [ADDR_WIDTH:0]   count_q;
  logic [ADDR_WIDTH:0]   count_in;
  logic [ADDR_WIDTH-1:0] rd_index_q;
  logic                  vld_q;
  logic [ADDR_WIDTH-1:0] vld_index_q;
  logic                  start_ok;
  logic                  last_addr;

  assign start_ok  = (state_q == ST_IDLE) && start;
  assign count_in  = (num_entries > DEPTH_W) ? DEPTH_W : num_entries;
  assign last_addr = ({1'b0, rd_index_q} == (count_q - ONE_W));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (num_entries == '0) ? ST_DONE : ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (last_addr) begin
          state_d = ST_DRAIN;
        end
      end
      // Wait until the final read has been compared (pipeline flag cleared).
      ST_DRAIN: begin
        if (!vld_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count_q    <= '0;
      rd_index_q <= '0;
    end else if (start_ok) begin
      count_q <= count_in;
      if (count_in != '0) begin
        rd_index_q <= '0;
      end
    end else if ((state_q == ST_SCAN) && !last_addr) begin
      rd_index_q <= rd_index_q + 1'b1;
    end
  end

  // Bank data arrives one cycle after its address, so the qualifier trails rd_en/rd_index.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      vld_q       <= 1'b0;
      vld_index_q <= '0;
    end else begin
      vld_q       <= rd_en;
      vld_index_q <= rd_index_q;
    end
  end

  assign rd_en    = (state_q == ST_SCAN);
  assign rd_index = rd_index_q;
  assign busy     = (state_q == ST_SCAN) || (state_q == ST_DRAIN);
  assign done     = (state_q == ST_DONE);

  membank_argmax_stage #(
    .WORD_WIDTH(WORD_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_stage (
    .clk       (clk),
    .nrst      (nrst),
    .clear     (start_ok),
    .valid     (vld_q),
    .index     (vld_index_q),
    .data      (rd_data),
    .found     (found),
    .best_index(best_index),
    .best_value(best_value)
  );

endmodule

// File: tb/tb_membank_argmax_reader.sv
// Bench for membank_argmax_reader: bank model, result/timing model, per-cycle compare, directed scenarios.
module tb_membank_argmax_reader;

  localparam int WW = 16;
  localparam int MD = 64;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   num_entries = '0;
  logic          rd_en;
  logic [AW-1:0] rd_index;
  logic [WW-1:0] rd_data;
  logic          busy;
  logic          done;
  logic          found;
  logic [AW-1:0] best_index;
  logic [WW-1:0] best_value;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  int rden_cnt = 0;
  int done_cnt = 0;

  logic [WW-1:0] mem [MD];

  always #5 clk = ~clk;

  membank_argmax_reader dut (
    .clk        (clk),
    .nrst       (nrst),
    .start      (start),
    .num_entries(num_entries),
    .rd_en      (rd_en),
    .rd_index   (rd_index),
    .rd_data    (rd_data),
    .busy       (busy),
    .done       (done),
    .found      (found),
    .best_index (best_index),
    .best_value (best_value)
  );

  // Bank read port: registered, data one cycle after address.
  always @(posedge clk) rd_data <= mem[rd_index];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  bit            m_active;
  int            m_cyc, m_n, m_done_cyc;
  logic          m_found;
  logic [AW-1:0] m_idx, m_rdidx;
  logic [WW-1:0] m_val;

  function automatic bit eligible(input logic [WW-1:0] v);
`ifdef MEMSCAN_SKIP_ZERO_EN
    return v != '0;
`else
    return 1'b1;
`endif
  endfunction

  // Maximum over eligible words, then the lowest index holding it.
  task automatic compute_result();
    logic [WW-1:0] mx = '0;
    bit any = 0;
    m_found = 0; m_idx = '0; m_val = '0;
    for (int i = 0; i < m_n; i++)
      if (eligible(mem[i])) begin
        if (!any || mem[i] > mx) mx = mem[i];
        any = 1;
      end
    if (any) begin
      m_found = 1; m_val = mx;
      for (int i = m_n - 1; i >= 0; i--)
        if (eligible(mem[i]) && mem[i] == mx) m_idx = AW'(i);
    end
  endtask

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_active = 0; m_cyc = 0; m_n = 0; m_done_cyc = 0;
      m_found = 0; m_idx = '0; m_val = '0; m_rdidx = '0;
    end else if (!m_active) begin
      if (start) begin
        m_n = (int'(num_entries) > MD) ? MD : int'(num_entries);
        compute_result();
        m_active = 1;
        m_cyc = 0;
        m_done_cyc = (m_n == 0) ? 0 : m_n + 2;
        if (m_n > 0) m_rdidx = '0;
      end
    end else if (m_cyc == m_done_cyc) begin
      m_active = 0;
    end else begin
      m_cyc++;
      if (m_cyc < m_n) m_rdidx = AW'(m_cyc);
    end
  end

  always @(negedge clk) begin
    if (rd_en) rden_cnt++;
    if (done) done_cnt++;
    if (cmp_en) begin
      chk("done", done, m_active && (m_cyc == m_done_cyc));
      chk("busy", busy, m_active && (m_n > 0) && (m_cyc <= m_n + 1));
      chk("rd_en", rd_en, m_active && (m_cyc < m_n));
      chk("rd_index", rd_index, m_rdidx);
      if (!m_active || m_cyc == m_done_cyc) begin
        chk("found", found, m_found);
        chk("best_index", best_index, m_idx);
        chk("best_value", best_value, m_val);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_start(input int n);
    @(negedge clk);
    start = 1'b1;
    num_entries = (AW+1)'(n);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // k = index of the cycle (counted from the start edge) in which done is seen.
  task automatic wait_done(output int k);
    bit seen = 0;
    k = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
      k++;
    end
    chk("done_within_bound", seen, 1);
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
    #1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, r0, d0;
    for (int i = 0; i < MD; i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_index", rd_index, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_found", found, 0);
    chk("rst_best_index", best_index, 0);
    chk("rst_best_value", best_value, 0);
    nrst = 1'b1;
    cmp_en = 1'b1;

    // 3,15,7,15 -> tie keeps index 1
    mem[0] = 3; mem[1] = 15; mem[2] = 7; mem[3] = 15;
    r0 = rden_cnt;
    do_start(4);
    wait_done(k);
    chk("t1_latency", k, 6);
    chk("t1_found", found, 1);
    chk("t1_best_index", best_index, 1);
    chk("t1_best_value", best_value, 15);
    settle();
    chk("t1_rd_en_cycles", rden_cnt - r0, 4);

    // empty scan
    r0 = rden_cnt;
    do_start(0);
    wait_done(k);
    chk("t2_latency", k, 0);
    chk("t2_found", found, 0);
    chk("t2_best_value", best_value, 0);
    settle();
    chk("t2_rd_en_cycles", rden_cnt - r0, 0);

    // full table, value = index
    for (int i = 0; i < MD; i++) mem[i] = WW'(i);
    do_start(64);
    wait_done(k);
    chk("t3_latency", k, 66);
    chk("t3_best_index", best_index, 63);
    chk("t3_best_value", best_value, 63);

    // single 40 at index 0
    for (int i = 0; i < MD; i++) mem[i] = '0;
    mem[0] = 40;
    do_start(64);
    wait_done(k);
    chk("t4_best_index", best_index, 0);
    chk("t4_best_value", best_value, 40);
    settle();
    chk("t4_rd_index_hold", rd_index, 63);

    // restart and num_entries change mid-scan are ignored
    for (int i = 0; i < 10; i++) mem[i] = WW'((i * 7) % 11);
    r0 = rden_cnt; d0 = done_cnt;
    do_start(10);
    repeat (3) @(negedge clk);
    start = 1'b1; num_entries = 2;
    @(negedge clk);
    start = 1'b0;
    wait_done(k);
    repeat (15) @(negedge clk);
    #1;
    chk("t5_done_pulses", done_cnt - d0, 1);
    chk("t5_rd_en_cycles", rden_cnt - r0, 10);
    chk("t5_best_index", best_index, 3);
    chk("t5_best_value", best_value, 10);

    // reset mid-scan
    mem[0] = 5; mem[1] = 9; mem[2] = 2; mem[3] = 9;
    mem[4] = 1; mem[5] = 0; mem[6] = 8; mem[7] = 3;
    d0 = done_cnt;
    do_start(8);
    @(negedge clk); @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    chk("t6_rst_rd_en", rd_en, 0);
    chk("t6_rst_rd_index", rd_index, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_found", found, 0);
    chk("t6_rst_best_index", best_index, 0);
    chk("t6_rst_best_value", best_value, 0);
    @(negedge clk);
    #2 nrst = 1'b1;
    settle();
    chk("t6_no_done_on_abort", done_cnt - d0, 0);
    do_start(8);
    wait_done(k);
    chk("t6_latency", k, 10);
    chk("t6_best_index", best_index, 1);
    chk("t6_best_value", best_value, 9);

    // all-zero table
    mem[0] = 0; mem[1] = 0; mem[2] = 0;
    do_start(3);
    wait_done(k);
`ifdef MEMSCAN_SKIP_ZERO_EN
    chk("t7_found", found, 0);
`else
    chk("t7_found", found, 1);
`endif
    chk("t7_best_index", best_index, 0);
    chk("t7_best_value", best_value, 0);
    settle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
